// File: rtl/lms_train_ctrl.sv
// lms_train_ctrl
//   Sequences an LMS adaptive-filter core through weight load, priming,
//   training until convergence (or a sample budget runs out), and a frozen
//   run phase. Streams samples into the core and watches its error output.
//
// Ports
//   Clk, Rst          clock, asynchronous active-high reset
//   start_i, abort_i  single-cycle control pulses
//   init_w_i          initial weights {w3,w2,w1,w0}, signed Q4.12 each
//   train_len_i       maximum training samples (0 treated as 1)
//   thresh_i          |err| limit, Q4.12 unsigned
//   conv_cnt_i        consecutive in-threshold samples for convergence (0 -> 1)
//   s_valid_i/s_ready_o/s_x_i/s_d_i   sample stream handshake and data
//   core_x_o, core_d_o, core_err_i    LMS core data path
//   training_en_o, load_weights_o, w_set_o   LMS core control
//   busy_o, converged_o, timeout_o, underrun_o, state_o, samp_cnt_o   status
module lms_train_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] init_w_i,
  input  logic [15:0] train_len_i,
  input  logic [15:0] thresh_i,
  input  logic [7:0]  conv_cnt_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [15:0] s_x_i,
  input  logic [15:0] s_d_i,
  output logic [15:0] core_x_o,
  output logic [15:0] core_d_o,
  input  logic [15:0] core_err_i,
  output logic        training_en_o,
  output logic        load_weights_o,
  output logic [63:0] w_set_o,
  output logic        busy_o,
  output logic        converged_o,
  output logic        timeout_o,
  output logic        underrun_o,
  output logic [2:0]  state_o,
  output logic [15:0] samp_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRIME = 3'd2,
    TRAIN = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] samp_cnt_q, samp_cnt_d;
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic [15:0] core_d_q, core_d_d;
  logic        converged_q, converged_d;
  logic        timeout_q, timeout_d;
  logic        underrun_q, underrun_d;

  logic        s_ready_s;
  logic        accept_s;
  logic        abort_act_s;
  logic [16:0] err_abs_s;
  logic        err_in_s;
  logic [15:0] samp_inc_s;
  logic [7:0]  run_inc_s;
  logic [7:0]  conv_tgt_s;
  logic [15:0] len_tgt_s;

  // Abort only has an effect outside IDLE.
  assign abort_act_s = abort_i && (state_q != IDLE);
  assign accept_s    = s_valid_i && s_ready_s;

  // -32768 has no positive 16-bit counterpart, hence the 17-bit magnitude.
  assign err_abs_s  = core_err_i[15] ? (17'd0 - {core_err_i[15], core_err_i})
                                     : {1'b0, core_err_i};
  assign err_in_s   = (err_abs_s <= {1'b0, thresh_i});
  assign samp_inc_s = (samp_cnt_q == 16'hFFFF) ? 16'hFFFF : (samp_cnt_q + 16'd1);
  assign run_inc_s  = err_in_s ? ((run_cnt_q == 8'hFF) ? 8'hFF : (run_cnt_q + 8'd1))
                               : 8'd0;
  assign conv_tgt_s = (conv_cnt_i == 8'd0) ? 8'd1 : conv_cnt_i;
  assign len_tgt_s  = (train_len_i == 16'd0) ? 16'd1 : train_len_i;

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      samp_cnt_q  <= 16'd0;
      run_cnt_q   <= 8'd0;
      core_d_q    <= 16'd0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      run_cnt_q   <= run_cnt_d;
      core_d_q    <= core_d_d;
      converged_q <= converged_d;
      timeout_q   <= timeout_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state and counter/flag update logic; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    run_cnt_d   = run_cnt_q;
    converged_d = converged_q;
    timeout_d   = timeout_q;
    underrun_d  = underrun_q;
    // d is registered so it lines up with the core's one-cycle-delayed x.
    if (accept_s) begin
      core_d_d = s_d_i;
    end else begin
      core_d_d = core_d_q;
    end

    if (abort_act_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN, DONE, FAULT: begin
          if (start_i) begin
            state_d     = LOAD;
            samp_cnt_d  = 16'd0;
            run_cnt_d   = 8'd0;
            converged_d = 1'b0;
            timeout_d   = 1'b0;
            underrun_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        LOAD: begin
          state_d = PRIME;
        end
        PRIME: begin
          if (accept_s) begin
            state_d    = TRAIN;
            samp_cnt_d = 16'd1;
          end else begin
            state_d = PRIME;
          end
        end
        TRAIN: begin
          if (!s_valid_i) begin
            state_d    = FAULT;
            underrun_d = 1'b1;
          end else begin
            samp_cnt_d = samp_inc_s;
            run_cnt_d  = run_inc_s;
            // Convergence is tested first so it wins a tie with the budget.
            if (run_inc_s >= conv_tgt_s) begin
              state_d     = RUN;
              converged_d = 1'b1;
            end else if (samp_inc_s >= len_tgt_s) begin
              state_d   = DONE;
              timeout_d = 1'b1;
            end else begin
              state_d = TRAIN;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Per-state output decode; an active abort drops all handshakes at once.
  always_comb begin
    s_ready_s      = 1'b0;
    training_en_o  = 1'b0;
    load_weights_o = 1'b0;
    busy_o         = 1'b0;
    case (state_q)
      LOAD: begin
        load_weights_o = !abort_act_s;
        busy_o         = 1'b1;
      end
      PRIME: begin
        s_ready_s = !abort_act_s;
        busy_o    = 1'b1;
      end
      TRAIN: begin
        s_ready_s     = !abort_act_s;
        training_en_o = s_valid_i && !abort_act_s;
        busy_o        = 1'b1;
      end
      RUN: begin
        s_ready_s = !abort_act_s;
      end
      default: begin
        s_ready_s = 1'b0;
      end
    endcase
  end

  assign s_ready_o   = s_ready_s;
  assign core_x_o    = accept_s ? s_x_i : 16'd0;
  assign core_d_o    = core_d_q;
  assign w_set_o     = init_w_i;
  assign converged_o = converged_q;
  assign timeout_o   = timeout_q;
  assign underrun_o  = underrun_q;
  assign state_o     = state_q;
  assign samp_cnt_o  = samp_cnt_q;

endmodule

// File: tb/tb_lms_train_ctrl.sv
module tb_lms_train_ctrl;

  logic        Clk;
  logic        Rst;
  logic        start_i, abort_i;
  logic [63:0] init_w_i;
  logic [15:0] train_len_i, thresh_i;
  logic [7:0]  conv_cnt_i;
  logic        s_valid_i, s_ready_o;
  logic [15:0] s_x_i, s_d_i;
  logic [15:0] core_x_o, core_d_o, core_err_i;
  logic        training_en_o, load_weights_o;
  logic [63:0] w_set_o;
  logic        busy_o, converged_o, timeout_o, underrun_o;
  logic [2:0]  state_o;
  logic [15:0] samp_cnt_o;

  int tests = 0;
  int fails = 0;

  lms_train_ctrl dut (
    .Clk(Clk), .Rst(Rst), .start_i(start_i), .abort_i(abort_i),
    .init_w_i(init_w_i), .train_len_i(train_len_i), .thresh_i(thresh_i),
    .conv_cnt_i(conv_cnt_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_x_i(s_x_i), .s_d_i(s_d_i), .core_x_o(core_x_o), .core_d_o(core_d_o),
    .core_err_i(core_err_i), .training_en_o(training_en_o),
    .load_weights_o(load_weights_o), .w_set_o(w_set_o), .busy_o(busy_o),
    .converged_o(converged_o), .timeout_o(timeout_o), .underrun_o(underrun_o),
    .state_o(state_o), .samp_cnt_o(samp_cnt_o)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    init_w_i = 64'h1000_0800_0400_0200;
    train_len_i = 16'd100; thresh_i = 16'h0010; conv_cnt_i = 8'd4;
    s_valid_i = 1'b0; s_x_i = 16'h0000; s_d_i = 16'h0000; core_err_i = 16'h0008;

    // Reset values
    tick(); tick();
    chk("rst_state", state_o, 3'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", s_ready_o, 1'b0);
    chk("rst_load", load_weights_o, 1'b0);
    chk("rst_samp", samp_cnt_o, 16'd0);
    chk("rst_cored", core_d_o, 16'd0);
    chk("rst_flags", {converged_o, timeout_o, underrun_o}, 3'b000);
    Rst = 1'b0;
    tick();

    // Load and prime
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    #1;
    chk("load_state", state_o, 3'd1);
    chk("load_pulse", load_weights_o, 1'b1);
    chk("load_wset", w_set_o, 64'h1000_0800_0400_0200);
    chk("load_busy", busy_o, 1'b1);
    chk("load_ready", s_ready_o, 1'b0);
    tick();
    chk("prime_state", state_o, 3'd2);
    chk("prime_load_off", load_weights_o, 1'b0);
    chk("prime_ready", s_ready_o, 1'b1);
    chk("prime_ten", training_en_o, 1'b0);
    s_valid_i = 1'b1; s_x_i = 16'h0123; s_d_i = 16'h0456;
    #1;
    chk("prime_corex", core_x_o, 16'h0123);
    tick();
    chk("train_state", state_o, 3'd3);
    chk("train_samp1", samp_cnt_o, 16'd1);
    chk("train_cored", core_d_o, 16'h0456);

    // Convergence after 4th TRAIN accept (err 8 <= thresh 16)
    for (int i = 0; i < 4; i++) begin
      s_d_i = 16'h0010 + 16'(i);
      #1;
      chk("conv_ten", training_en_o, 1'b1);
      tick();
      chk("conv_cored", core_d_o, 16'h0010 + 16'(i));
      if (i < 3) begin
        chk("conv_still_train", state_o, 3'd3);
        chk("conv_samp", samp_cnt_o, 16'd2 + 16'(i));
      end else begin
        chk("conv_run", state_o, 3'd4);
        chk("conv_flag", converged_o, 1'b1);
        chk("conv_samp5", samp_cnt_o, 16'd5);
      end
    end
    chk("run_ten", training_en_o, 1'b0);
    chk("run_ready", s_ready_o, 1'b1);
    chk("run_busy", busy_o, 1'b0);
    s_valid_i = 1'b0;
    #1;
    chk("run_corex_gap", core_x_o, 16'h0000);
    tick();
    chk("run_hold", state_o, 3'd4);
    chk("run_cored_hold", core_d_o, 16'h0013);

    // Abort in RUN keeps flags
    abort_i = 1'b1; s_valid_i = 1'b1;
    #1;
    chk("abort_ready", s_ready_o, 1'b0);
    tick();
    abort_i = 1'b0; s_valid_i = 1'b0;
    chk("abort_idle", state_o, 3'd0);
    chk("abort_keep_conv", converged_o, 1'b1);

    // Timeout: train_len 10, err 0x100 > thresh
    train_len_i = 16'd10; core_err_i = 16'h0100;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("to_conv_clr", converged_o, 1'b0);
    tick();
    s_valid_i = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) chk("to_train", state_o, 3'd3);
    end
    s_valid_i = 1'b0;
    chk("to_done", state_o, 3'd5);
    chk("to_flag", timeout_o, 1'b1);
    chk("to_samp", samp_cnt_o, 16'd10);
    chk("to_no_conv", converged_o, 1'b0);
    chk("done_ready", s_ready_o, 1'b0);

    // Underrun on 3rd TRAIN cycle; start ignored during TRAIN
    train_len_i = 16'd100;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("ur_state_load", state_o, 3'd1);
    chk("ur_to_clr", timeout_o, 1'b0);
    tick();
    s_valid_i = 1'b1; tick();
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("ur_start_ignored", state_o, 3'd3);
    chk("ur_samp3", samp_cnt_o, 16'd3);
    s_valid_i = 1'b0;
    #1;
    chk("ur_ten", training_en_o, 1'b0);
    tick();
    chk("ur_fault", state_o, 3'd6);
    chk("ur_flag", underrun_o, 1'b1);
    chk("ur_busy", busy_o, 1'b0);

    // Abort beats convergence
    core_err_i = 16'h0008;
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    s_valid_i = 1'b1; tick();
    tick(); tick(); tick();
    abort_i = 1'b1;
    #1;
    chk("ab_ten", training_en_o, 1'b0);
    tick();
    abort_i = 1'b0; s_valid_i = 1'b0;
    chk("ab_idle", state_o, 3'd0);
    chk("ab_conv0", converged_o, 1'b0);
    chk("ab_samp", samp_cnt_o, 16'd4);

    // |-32768| = 32768: inside 0xFFFF, outside 0x7FFF
    core_err_i = 16'h8000; conv_cnt_i = 8'd2; thresh_i = 16'hFFFF;
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    s_valid_i = 1'b1; tick();
    tick();
    thresh_i = 16'h7FFF; tick();
    thresh_i = 16'hFFFF; tick();
    chk("neg_still_train", state_o, 3'd3);
    tick();
    chk("neg_run", state_o, 3'd4);
    chk("neg_conv", converged_o, 1'b1);
    chk("neg_samp", samp_cnt_o, 16'd5);

    // Start from RUN, then Rst mid-TRAIN
    core_err_i = 16'h0008; thresh_i = 16'h0010; conv_cnt_i = 8'd4;
    s_valid_i = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("rs_load", state_o, 3'd1);
    chk("rs_conv_clr", converged_o, 1'b0);
    tick();
    s_valid_i = 1'b1; s_d_i = 16'h0777; tick();
    tick();
    #2;
    Rst = 1'b1;
    #1;
    chk("rs_state", state_o, 3'd0);
    chk("rs_samp", samp_cnt_o, 16'd0);
    chk("rs_cored", core_d_o, 16'd0);
    chk("rs_ten", training_en_o, 1'b0);
    chk("rs_ready", s_ready_o, 1'b0);
    chk("rs_busy", busy_o, 1'b0);
    Rst = 1'b0;
    s_valid_i = 1'b0;
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("rs2_load", load_weights_o, 1'b1);
    tick();
    s_valid_i = 1'b1; tick();
    tick(); tick(); tick(); tick();
    s_valid_i = 1'b0;
    chk("rs2_run", state_o, 3'd4);
    chk("rs2_conv", converged_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lms_train_ctrl.md
LMS_TRAIN_CTRL -- requirements
Module: lms_train_ctrl

Interface
REQ-001 SHALL have ports: Clk in 1, clock; Rst in 1, reset; Rst asynchronous, active-high; clock Clk.
REQ-002 SHALL have start in 1: single-cycle pulse that begins a training sequence.
REQ-003 SHALL have abort in 1: single-cycle pulse that returns the block to IDLE.
REQ-004 SHALL have init_w in 64: initial weights {w3,w2,w1,w0}, each signed Q4.12.
REQ-005 SHALL have train_len in 16 (unsigned max training samples) and thresh in 16 (unsigned |err| limit, Q4.12).
REQ-006 SHALL have conv_cnt in 8: consecutive in-threshold samples required to declare convergence.
REQ-007 SHALL have s_valid in 1, s_ready out 1, s_x in 16 signed and s_d in 16 signed: the sample stream.
REQ-008 SHALL have core_x out 16, core_d out 16, core_err in 16 signed, training_en out 1, load_weights out 1 and w_set out 64: the LMS core drive.
REQ-009 SHALL have busy, converged, timeout and underrun out 1 each; state out 3; samp_cnt out 16.

Function
REQ-010 States SHALL be IDLE=0, LOAD=1, PRIME=2, TRAIN=3, RUN=4, DONE=5, FAULT=6; state SHALL be registered.
REQ-011 IDLE: s_ready=0; start SHALL move to LOAD, clearing converged, timeout, underrun, samp_cnt and the run counter.
REQ-012 LOAD: load_weights=1 for exactly one cycle, w_set=init_w; next state PRIME; w_set SHALL hold init_w at all other times.
REQ-013 PRIME: s_ready=1, training_en=0; the first accept (s_valid&s_ready) SHALL move to TRAIN and set samp_cnt=1.
REQ-014 core_x SHALL equal s_x when s_valid&s_ready, else 0 (combinational).
REQ-015 core_d SHALL be s_d registered on each accept, aligning d with the core's delayed x; it SHALL hold otherwise.
REQ-016 TRAIN: s_ready=1; training_en SHALL equal s_valid (combinational); each accept SHALL increment samp_cnt.
REQ-017 TRAIN with s_valid=0 SHALL be an underrun: training_en=0 that cycle, next state FAULT, underrun=1.
REQ-018 TRAIN, each accepted cycle: |core_err| SHALL be computed as 17-bit unsigned (-32768 -> 32768). If it is <= thresh the run counter SHALL increment, else clear to 0.
REQ-019 When the incremented run counter reaches max(conv_cnt,1), the block SHALL set converged=1 and move to RUN.
REQ-020 When samp_cnt after increment reaches max(train_len,1) without convergence, the block SHALL set timeout=1 and move to DONE.
REQ-021 If convergence and train_len are reached in the same cycle, convergence SHALL win (converged=1, timeout=0, RUN).
REQ-022 RUN: s_ready=1, training_en=0; weights stay frozen; s_valid gaps are permitted (core_x=0 per REQ-014); RUN SHALL remain until abort or start.
REQ-023 DONE, FAULT: s_ready=0, training_en=0; flags SHALL hold; start restarts the sequence at LOAD.
REQ-024 start in RUN, DONE or FAULT SHALL behave as in IDLE (REQ-011); start in LOAD, PRIME or TRAIN SHALL be ignored.
REQ-025 abort in any non-IDLE state SHALL force IDLE next cycle, drop training_en/load_weights/s_ready that cycle and keep flags; abort SHALL beat start, convergence, timeout and underrun in the same cycle.
REQ-026 busy SHALL be 1 in LOAD, PRIME and TRAIN, else 0.
REQ-027 samp_cnt SHALL saturate at 65535.

Reset
REQ-028 Rst SHALL force: state IDLE, run counter 0, samp_cnt 0, core_d 0, all flags 0.
REQ-029 During Rst: training_en, load_weights, s_ready and busy SHALL be 0.
REQ-030 Rst mid-TRAIN SHALL take effect immediately without waiting for a clock edge.

Verification
REQ-031 Scenario: start, init_w=0x1000_0800_0400_0200 -> one load_weights cycle carrying init_w, then PRIME with s_ready=1.
REQ-032 Scenario: thresh=0x0010, conv_cnt=4, core_err held at 0x0008 -> converged=1 and RUN after the 4th TRAIN accept; training_en=0 thereafter.
REQ-033 Scenario: train_len=10, core_err=0x0100, thresh=0x0010 -> timeout=1, DONE at samp_cnt=10.
REQ-034 Scenario: s_valid drops on the 3rd TRAIN cycle -> training_en=0 that cycle, then FAULT with underrun=1.
REQ-035 Scenario: abort and convergence in the same cycle -> IDLE, converged=0; core_err=0x8000 with thresh=0xFFFF -> counted as in-threshold.
REQ-036 Scenario: Rst pulsed mid-TRAIN -> all outputs at reset values immediately; a subsequent start resumes normally.
